// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: CB sequencer states, ALU operation codes
// and register-file indices.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REG,
    HL_READ,
    HL_BIT,
    HL_MODIFY,
    FETCH
  } cb_state_t;

  localparam logic [1:0] ALU_SHIFT = 2'd0;
  localparam logic [1:0] ALU_BIT   = 2'd1;
  localparam logic [1:0] ALU_RES   = 2'd2;
  localparam logic [1:0] ALU_SET   = 2'd3;

  localparam logic [2:0] REG_B   = 3'd0;
  localparam logic [2:0] REG_C   = 3'd1;
  localparam logic [2:0] REG_D   = 3'd2;
  localparam logic [2:0] REG_E   = 3'd3;
  localparam logic [2:0] REG_H   = 3'd4;
  localparam logic [2:0] REG_L   = 3'd5;
  localparam logic [2:0] REG_TMP = 3'd6;
  localparam logic [2:0] REG_A   = 3'd7;

  function automatic logic [7:0] reg_sel(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/cb_sequencer_if.sv
// Control/strobe bundle between the CB sequencer and its upstream/datapath.
interface cb_sequencer_if #(
  parameter int unsigned STEPS_PER_CYCLE = 4
);
  logic                       i_Stall;
  logic                       i_Start;
  logic [7:0]                 i_Opcode;
  logic [STEPS_PER_CYCLE-1:0] o_Step;
  logic [1:0]                 o_MCycle;
  logic                       o_Busy;
  logic [7:0]                 o_Read8;
  logic [7:0]                 o_Write8;
  logic                       o_ALU_En;
  logic [1:0]                 o_ALU_Op;
  logic [2:0]                 o_ALU_Sub;
  logic                       o_Flag_Write;
  logic                       o_Address_Out;
  logic                       o_Bus_In;
  logic                       o_Bus_Out;
  logic                       o_IR_Fetch;
  logic                       o_Done;

  modport master (
    output i_Stall, i_Start, i_Opcode,
    input  o_Step, o_MCycle, o_Busy, o_Read8, o_Write8, o_ALU_En, o_ALU_Op,
           o_ALU_Sub, o_Flag_Write, o_Address_Out, o_Bus_In, o_Bus_Out,
           o_IR_Fetch, o_Done
  );

  modport slave (
    input  i_Stall, i_Start, i_Opcode,
    output o_Step, o_MCycle, o_Busy, o_Read8, o_Write8, o_ALU_En, o_ALU_Op,
           o_ALU_Sub, o_Flag_Write, o_Address_Out, o_Bus_In, o_Bus_Out,
           o_IR_Fetch, o_Done
  );
endinterface

// File: rtl/step_ring.sv
// One-hot T-step rotator; holds while stalled, flags the wrap from the last
// step back to step 0.
module step_ring #(
  parameter int unsigned STEPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [STEPS-1:0] step,
  output logic             wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= STEPS'(1);
    end else if (!stall) begin
      step <= {step[STEPS-2:0], step[STEPS-1]};
    end
  end

  assign wrap = step[STEPS-1] & ~stall;

endmodule

// File: rtl/cb_sequencer.sv
// CB-prefix opcode sequencer: walks register or (HL) operand M-cycles and
// decodes one-hot datapath strobes from state, T-step and latched opcode.
module cb_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEPS_PER_CYCLE = 4,
  parameter int unsigned ADDR_STEP       = 1,
  parameter int unsigned ALU_STEP        = 2,
  parameter int unsigned DATA_STEP       = 3
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  cb_sequencer_if.slave  bus
);

  cb_state_t                  state, state_nxt;
  logic [1:0]                 mcycle, mcycle_nxt;
  logic [7:0]                 opcode, opcode_nxt;
  logic [STEPS_PER_CYCLE-1:0] step;
  logic                       wrap;
  logic                       busy;
  logic                       is_bit;
  logic                       no_flags;
  logic [2:0]                 r;

  logic [7:0] read8, write8;
  logic       alu_en, flag_write, addr_out, bus_in, bus_out, ir_fetch;

  step_ring #(.STEPS(STEPS_PER_CYCLE)) u_step_ring (
    .clk   (i_Clk),
    .rst   (i_Reset),
    .stall (bus.i_Stall),
    .step  (step),
    .wrap  (wrap)
  );

  assign busy     = (state != IDLE);
  assign r        = opcode[2:0];
  assign is_bit   = (opcode[7:6] == ALU_BIT);
  assign no_flags = (opcode[7:6] == ALU_RES) || (opcode[7:6] == ALU_SET);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state  <= IDLE;
      mcycle <= '0;
      opcode <= '0;
    end else begin
      state  <= state_nxt;
      mcycle <= mcycle_nxt;
      opcode <= opcode_nxt;
    end
  end

  // All transitions happen on the ring wrap, which already excludes stall.
  always_comb begin
    state_nxt  = state;
    mcycle_nxt = mcycle;
    opcode_nxt = opcode;
    if (wrap) begin
      case (state)
        IDLE: begin
          if (bus.i_Start) begin
            opcode_nxt = bus.i_Opcode;
            state_nxt  = (bus.i_Opcode[2:0] == REG_TMP) ? HL_READ : REG;
          end
        end
        REG:       state_nxt = IDLE;
        HL_READ:   state_nxt = is_bit ? HL_BIT : HL_MODIFY;
        HL_BIT:    state_nxt = IDLE;
        HL_MODIFY: state_nxt = FETCH;
        FETCH:     state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
      if (state != IDLE) begin
        mcycle_nxt = (state_nxt == IDLE) ? 2'd0 : mcycle + 2'd1;
      end else begin
        mcycle_nxt = '0;
      end
    end
  end

  always_comb begin
    read8      = '0;
    write8     = '0;
    alu_en     = 1'b0;
    flag_write = 1'b0;
    addr_out   = 1'b0;
    bus_in     = 1'b0;
    bus_out    = 1'b0;
    ir_fetch   = 1'b0;
    case (state)
      REG: begin
        ir_fetch = 1'b1;
        if (step[ALU_STEP]) begin
          alu_en     = 1'b1;
          read8      = reg_sel(r);
          flag_write = ~no_flags;
          if (!is_bit) write8 = reg_sel(r);
        end
      end
      HL_READ: begin
        addr_out = step[ADDR_STEP];
        if (step[DATA_STEP]) begin
          bus_in = 1'b1;
          write8 = reg_sel(REG_TMP);
        end
      end
      HL_BIT: begin
        ir_fetch = 1'b1;
        if (step[ALU_STEP]) begin
          alu_en     = 1'b1;
          read8      = reg_sel(REG_TMP);
          flag_write = 1'b1;
        end
      end
      HL_MODIFY: begin
        addr_out = step[ADDR_STEP];
        if (step[ALU_STEP]) begin
          alu_en     = 1'b1;
          read8      = reg_sel(REG_TMP);
          write8     = reg_sel(REG_TMP);
          flag_write = ~no_flags;
        end
        if (step[DATA_STEP]) begin
          bus_out = 1'b1;
          read8   = reg_sel(REG_TMP);
        end
      end
      FETCH:   ir_fetch = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_Step        = step;
  assign bus.o_MCycle      = mcycle;
  assign bus.o_Busy        = busy;
  assign bus.o_Read8       = read8;
  assign bus.o_Write8      = write8;
  assign bus.o_ALU_En      = alu_en;
  assign bus.o_ALU_Op      = busy ? opcode[7:6] : 2'd0;
  assign bus.o_ALU_Sub     = busy ? opcode[5:3] : 3'd0;
  assign bus.o_Flag_Write  = flag_write;
  assign bus.o_Address_Out = addr_out;
  assign bus.o_Bus_In      = bus_in;
  assign bus.o_Bus_Out     = bus_out;
  assign bus.o_IR_Fetch    = ir_fetch;
  assign bus.o_Done        = ir_fetch & step[STEPS_PER_CYCLE-1] & ~bus.i_Stall;

endmodule

// File: tb/tb_cb_sequencer.sv
// Scoreboard bench for cb_sequencer: 4-step default instance and an 8-step
// instance, with hand-written per-step expected strobe records.
module tb_cb_sequencer;

  typedef struct packed {
    logic [7:0] step;
    logic [1:0] mc;
    logic [7:0] rd;
    logic [7:0] wr;
    logic [1:0] op;
    logic [2:0] sub;
    logic [6:0] ctl;  // alu_en, flag, addr, bus_in, bus_out, ir_fetch, done
  } rec_t;

  localparam logic [6:0] C_ALU  = 7'b1000000;
  localparam logic [6:0] C_FLG  = 7'b0100000;
  localparam logic [6:0] C_ADR  = 7'b0010000;
  localparam logic [6:0] C_BIN  = 7'b0001000;
  localparam logic [6:0] C_BOUT = 7'b0000100;
  localparam logic [6:0] C_IRF  = 7'b0000010;
  localparam logic [6:0] C_DONE = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t q0[$];
  rec_t q1[$];
  logic [1:0] cur_op;
  logic [2:0] cur_sub;

  cb_sequencer_if #(.STEPS_PER_CYCLE(4)) if0();
  cb_sequencer_if #(.STEPS_PER_CYCLE(8)) if1();

  cb_sequencer #(.STEPS_PER_CYCLE(4), .ADDR_STEP(1), .ALU_STEP(2), .DATA_STEP(3)) dut0 (
    .i_Clk(clk), .i_Reset(rst), .bus(if0)
  );
  cb_sequencer #(.STEPS_PER_CYCLE(8), .ADDR_STEP(1), .ALU_STEP(5), .DATA_STEP(7)) dut1 (
    .i_Clk(clk), .i_Reset(rst), .bus(if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cmp(input string name, input rec_t a, input rec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got step=%h mc=%0d rd=%h wr=%h op=%0d sub=%0d ctl=%b want step=%h mc=%0d rd=%h wr=%h op=%0d sub=%0d ctl=%b",
               name, a.step, a.mc, a.rd, a.wr, a.op, a.sub, a.ctl,
               e.step, e.mc, e.rd, e.wr, e.op, e.sub, e.ctl);
    end
  endtask

  task automatic push(input int unit, input int mc, input int s,
                      input logic [7:0] rd, input logic [7:0] wr, input logic [6:0] ctl);
    rec_t e;
    e.step = 8'(1) << s;
    e.mc   = 2'(mc);
    e.rd   = rd;
    e.wr   = wr;
    e.op   = cur_op;
    e.sub  = cur_sub;
    e.ctl  = ctl;
    if (unit == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_range(input int unit, input int mc, input int s0, input int s1,
                            input logic [6:0] ctl);
    for (int s = s0; s <= s1; s++) push(unit, mc, s, 8'h00, 8'h00, ctl);
  endtask

  // 4-step (HL) read cycle: address at step 1, TMP load at step 3.
  task automatic push_hl_read();
    push(0, 0, 0, 8'h00, 8'h00, 7'b0);
    push(0, 0, 1, 8'h00, 8'h00, C_ADR);
    push(0, 0, 2, 8'h00, 8'h00, 7'b0);
    push(0, 0, 3, 8'h00, 8'h40, C_BIN);
  endtask

  task automatic start_op(input int unit, input logic [7:0] op);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      if (unit == 0 && if0.o_Step[3] && !if0.o_Busy) break;
      if (unit == 1 && if1.o_Step[7] && !if1.o_Busy) break;
      n++;
    end
    chk("start_window_timeout", 32'(n >= 40), 32'd0);
    if (unit == 0) begin if0.i_Start = 1'b1; if0.i_Opcode = op; end
    else begin if1.i_Start = 1'b1; if1.i_Opcode = op; end
    @(posedge clk); #1;
    if0.i_Start = 1'b0;
    if1.i_Start = 1'b0;
  endtask

  task automatic wait_idle(input int unit, output int waited);
    int n;
    n = 0;
    while (n < 100) begin
      if (unit == 0 && !if0.o_Busy) break;
      if (unit == 1 && !if1.o_Busy) break;
      @(posedge clk); #1;
      n++;
    end
    waited = n;
    chk("idle_timeout", 32'(n >= 100), 32'd0);
  endtask

  always @(negedge clk) begin
    rec_t a;
    if (!rst) begin
      a = '{step: 8'(if0.o_Step), mc: if0.o_MCycle, rd: if0.o_Read8, wr: if0.o_Write8,
            op: if0.o_ALU_Op, sub: if0.o_ALU_Sub,
            ctl: {if0.o_ALU_En, if0.o_Flag_Write, if0.o_Address_Out, if0.o_Bus_In,
                  if0.o_Bus_Out, if0.o_IR_Fetch, if0.o_Done}};
      if (if0.o_Busy) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut4_unexpected_busy got step=%h want idle", a.step);
        end else cmp("dut4_step", a, q0.pop_front());
      end else begin
        a.step = '0;
        cmp("dut4_idle", a, '0);
      end
    end
  end

  always @(negedge clk) begin
    rec_t a;
    if (!rst) begin
      a = '{step: if1.o_Step, mc: if1.o_MCycle, rd: if1.o_Read8, wr: if1.o_Write8,
            op: if1.o_ALU_Op, sub: if1.o_ALU_Sub,
            ctl: {if1.o_ALU_En, if1.o_Flag_Write, if1.o_Address_Out, if1.o_Bus_In,
                  if1.o_Bus_Out, if1.o_IR_Fetch, if1.o_Done}};
      if (if1.o_Busy) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut8_unexpected_busy got step=%h want idle", a.step);
        end else cmp("dut8_step", a, q1.pop_front());
      end else begin
        a.step = '0;
        cmp("dut8_idle", a, '0);
      end
    end
  end

  initial begin
    int t0, w, n;
    if0.i_Stall = 1'b0; if0.i_Start = 1'b0; if0.i_Opcode = 8'h00;
    if1.i_Stall = 1'b0; if1.i_Start = 1'b0; if1.i_Opcode = 8'h00;
    #12;
    chk("rst_step4", 32'(if0.o_Step), 32'h1);
    chk("rst_step8", 32'(if1.o_Step), 32'h1);
    chk("rst_mc4", 32'(if0.o_MCycle), 32'd0);
    chk("rst_outs4", {3'b0, if0.o_Read8, if0.o_Write8, if0.o_ALU_Op, if0.o_ALU_Sub,
                      if0.o_ALU_En, if0.o_Flag_Write, if0.o_Address_Out, if0.o_Bus_In,
                      if0.o_Bus_Out, if0.o_IR_Fetch, if0.o_Done, if0.o_Busy}, 32'd0);
    chk("rst_outs8", {3'b0, if1.o_Read8, if1.o_Write8, if1.o_ALU_Op, if1.o_ALU_Sub,
                      if1.o_ALU_En, if1.o_Flag_Write, if1.o_Address_Out, if1.o_Bus_In,
                      if1.o_Bus_Out, if1.o_IR_Fetch, if1.o_Done, if1.o_Busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SWAP A
    cur_op = 2'd0; cur_sub = 3'd6;
    push(0, 0, 0, 8'h00, 8'h00, C_IRF);
    push(0, 0, 1, 8'h00, 8'h00, C_IRF);
    push(0, 0, 2, 8'h80, 8'h80, C_ALU | C_FLG | C_IRF);
    push(0, 0, 3, 8'h00, 8'h00, C_IRF | C_DONE);
    start_op(0, 8'h37); t0 = cyc;
    wait_idle(0, w);
    chk("swap_latency", 32'(cyc - t0), 32'd4);
    chk("swap_drained", 32'(q0.size()), 32'd0);

    // BIT 0,(HL)
    cur_op = 2'd1; cur_sub = 3'd0;
    push_hl_read();
    push(0, 1, 0, 8'h00, 8'h00, C_IRF);
    push(0, 1, 1, 8'h00, 8'h00, C_IRF);
    push(0, 1, 2, 8'h40, 8'h00, C_ALU | C_FLG | C_IRF);
    push(0, 1, 3, 8'h00, 8'h00, C_IRF | C_DONE);
    start_op(0, 8'h46); t0 = cyc;
    wait_idle(0, w);
    chk("bithl_latency", 32'(cyc - t0), 32'd8);
    chk("bithl_drained", 32'(q0.size()), 32'd0);

    // SET 7,(HL), then again with a 5-clock stall in M0 step 1
    cur_op = 2'd3; cur_sub = 3'd7;
    for (int pass = 0; pass < 2; pass++) begin
      push(0, 0, 0, 8'h00, 8'h00, 7'b0);
      for (int k = 0; k < (pass == 0 ? 1 : 6); k++) push(0, 0, 1, 8'h00, 8'h00, C_ADR);
      push(0, 0, 2, 8'h00, 8'h00, 7'b0);
      push(0, 0, 3, 8'h00, 8'h40, C_BIN);
      push(0, 1, 0, 8'h00, 8'h00, 7'b0);
      push(0, 1, 1, 8'h00, 8'h00, C_ADR);
      push(0, 1, 2, 8'h40, 8'h40, C_ALU);
      push(0, 1, 3, 8'h40, 8'h00, C_BOUT);
      push_range(0, 2, 0, 2, C_IRF);
      push(0, 2, 3, 8'h00, 8'h00, C_IRF | C_DONE);
      start_op(0, 8'hFE); t0 = cyc;
      if (pass == 1) begin
        @(posedge clk); #1;
        if0.i_Stall = 1'b1;
        repeat (5) @(posedge clk);
        #1 if0.i_Stall = 1'b0;
      end
      wait_idle(0, w);
      chk(pass == 0 ? "sethl_latency" : "sethl_stall_latency", 32'(cyc - t0),
          pass == 0 ? 32'd12 : 32'd17);
      chk("sethl_drained", 32'(q0.size()), 32'd0);
    end

    // RLC (HL) aborted by reset in M1; a second start while busy is ignored
    cur_op = 2'd0; cur_sub = 3'd0;
    push_hl_read();
    push(0, 1, 0, 8'h00, 8'h00, 7'b0);
    push(0, 1, 1, 8'h00, 8'h00, C_ADR);
    start_op(0, 8'h06);
    if0.i_Start = 1'b1; if0.i_Opcode = 8'hFF;
    n = 0;
    while (n < 40 && !(if0.o_MCycle == 2'd1 && if0.o_Step == 4'b0010)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rlc_m1_timeout", 32'(n >= 40), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    if0.i_Start = 1'b0;
    #1;
    chk("abort_step", 32'(if0.o_Step), 32'h1);
    chk("abort_mc", 32'(if0.o_MCycle), 32'd0);
    chk("abort_outs", {3'b0, if0.o_Read8, if0.o_Write8, if0.o_ALU_Op, if0.o_ALU_Sub,
                       if0.o_ALU_En, if0.o_Flag_Write, if0.o_Address_Out, if0.o_Bus_In,
                       if0.o_Bus_Out, if0.o_IR_Fetch, if0.o_Done, if0.o_Busy}, 32'd0);
    chk("abort_drained", 32'(q0.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SWAP A again after the abort
    cur_op = 2'd0; cur_sub = 3'd6;
    push(0, 0, 0, 8'h00, 8'h00, C_IRF);
    push(0, 0, 1, 8'h00, 8'h00, C_IRF);
    push(0, 0, 2, 8'h80, 8'h80, C_ALU | C_FLG | C_IRF);
    push(0, 0, 3, 8'h00, 8'h00, C_IRF | C_DONE);
    start_op(0, 8'h37);
    wait_idle(0, w);
    chk("swap2_drained", 32'(q0.size()), 32'd0);

    // RL B on the 8-step instance
    cur_op = 2'd0; cur_sub = 3'd2;
    push_range(1, 0, 0, 4, C_IRF);
    push(1, 0, 5, 8'h01, 8'h01, C_ALU | C_FLG | C_IRF);
    push(1, 0, 6, 8'h00, 8'h00, C_IRF);
    push(1, 0, 7, 8'h00, 8'h00, C_IRF | C_DONE);
    start_op(1, 8'h10); t0 = cyc;
    wait_idle(1, w);
    chk("rlb8_latency", 32'(cyc - t0), 32'd8);
    chk("rlb8_drained", 32'(q1.size()), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cb_sequencer.md
Name: cb_sequencer

Overview:
- Sequential successor to the combinational CB-prefix microcode decoder in the CPU control unit.
- Owns its own T-step ring and M-cycle counter, and latches the CB opcode byte.
- Walks register or (HL) operand sequences, and gives BIT (HL) a shorter no-writeback path.
- Emits one-hot register-file, ALU, address and bus strobes to the datapath. Step positions and step count are parametrised.

Parameters:
- STEPS_PER_CYCLE, 4, T-steps per M-cycle; legal range 3..8.
- ADDR_STEP, 1, step index at which o_Address_Out asserts; must be < DATA_STEP.
- ALU_STEP, 2, step index of the ALU / register-file strobes.
- DATA_STEP, 3, step index of the memory read/write strobe; must be < STEPS_PER_CYCLE.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  asynchronous active-high reset
- i_Stall  in  1  memory wait; freezes step ring, M-cycle counter and state
- i_Start  in  1  CB prefix executed; opcode byte valid on i_Opcode
- i_Opcode  in  8  CB opcode byte
- o_Step  out  STEPS_PER_CYCLE  one-hot current T-step
- o_MCycle  out  2  M-cycle index within the CB op
- o_Busy  out  1  sequence in progress
- o_Read8  out  8  one-hot register read select: B,C,D,E,H,L,TMP,A = bits 0..7
- o_Write8  out  8  one-hot register write select, same bit order
- o_ALU_En  out  1  ALU strobe
- o_ALU_Op  out  2  opcode[7:6]: 0 shift/rotate, 1 BIT, 2 RES, 3 SET
- o_ALU_Sub  out  3  opcode[5:3]: shift kind or bit number
- o_Flag_Write  out  1  commit flags
- o_Address_Out  out  1  drive HL onto the address bus
- o_Bus_In  out  1  latch the data bus into TMP
- o_Bus_Out  out  1  drive TMP onto the data bus
- o_IR_Fetch  out  1  final M-cycle; the next opcode fetch overlaps it
- o_Done  out  1  one-clock pulse on the final step; clears CB mode upstream

Behaviour:
- Reset, asynchronous:
  - state IDLE, o_Step = 1 (step 0), o_MCycle = 0, opcode register = 0.
  - All other outputs 0.
- Step ring:
  - Free-running whenever i_Stall = 0; rotates left and wraps STEPS_PER_CYCLE-1 -> 0.
  - o_MCycle increments on the wrap while busy.
  - While i_Stall = 1, all registers hold and the strobes stay asserted at their held values.
- Start:
  - i_Start is sampled only when IDLE, on the last step, with i_Stall = 0.
  - The opcode is latched, o_Busy = 1 from the next clock and o_MCycle = 0.
  - i_Start while busy is ignored; the latched opcode does not change.
- Decode: r = opcode[2:0]; r = 6 selects (HL), r != 6 selects register r.
- REG sequence (1 M-cycle):
  - Step ALU_STEP: o_ALU_En = 1, o_Read8[r] = 1, o_Flag_Write = 1 unless RES/SET.
  - Same step: o_Write8[r] = 1 unless BIT.
  - o_IR_Fetch = 1 for the whole M-cycle.
- HL_READ sequence (M0):
  - Step ADDR_STEP: o_Address_Out = 1.
  - Step DATA_STEP: o_Bus_In = 1 and o_Write8[6] = 1 (TMP load).
- HL_BIT sequence (M1):
  - Step ALU_STEP: o_ALU_En = 1, o_Read8[6] = 1, o_Flag_Write = 1.
  - o_IR_Fetch = 1 for the whole M-cycle. Total 2 M-cycles.
- HL_MODIFY sequence (M1, then M2):
  - M1, step ALU_STEP: o_ALU_En = 1, o_Read8[6] = o_Write8[6] = 1, o_Flag_Write = 1 unless RES/SET.
  - M1, step ADDR_STEP: o_Address_Out = 1.
  - M1, step DATA_STEP: o_Bus_Out = 1 and o_Read8[6] = 1.
  - M2: o_IR_Fetch = 1. Total 3 M-cycles.
- Done and return to IDLE:
  - o_Done = o_IR_Fetch & o_Step[last] & !i_Stall.
  - Return to IDLE on the same edge.
  - Back-to-back: a new i_Start is accepted on the o_Done step only if the sequencer is already IDLE, so it is never accepted there; upstream re-executes the prefix first.
- Reset mid-sequence: immediate abort to IDLE. No partial write is issued after reset deassertion.
- All strobes are combinational decodes of the registered state, step and opcode; none are asserted in IDLE.

Decomposition:
- Shared package, cpu_ctrl_pkg:
  - state enum (IDLE, REG, HL_READ, HL_BIT, HL_MODIFY, FETCH);
  - ALU_OP encodings;
  - register index constants (REG_B..REG_A, REG_TMP = 6).
- One natural sub-module: step_ring (one-hot rotator with stall and wrap output), reused by the main opcode sequencer.

Test Plan:
- i_Start with 0x37 (SWAP A) -> one M-cycle.
  - Step 2: o_Read8 = o_Write8 = 0x80, o_ALU_Op = 0, o_ALU_Sub = 6, o_Flag_Write = 1.
  - o_Done on step 3.
- 0x46 (BIT 0,(HL)) -> 2 M-cycles.
  - M0: o_Address_Out at step 1, o_Bus_In at step 3.
  - M1: o_Read8 = 0x40, o_Write8 = 0 throughout, o_Bus_Out never asserted.
  - o_Done at M1 step 3.
- 0xFE (SET 7,(HL)) -> 3 M-cycles.
  - M1: o_Flag_Write = 0, o_Bus_Out at step 3.
  - o_IR_Fetch high for all of M2.
- 0xFE with i_Stall held for 5 clocks during M0 step 1 -> all outputs frozen, and the sequence completes exactly 5 clocks late.
- Reset asserted during M1 of 0x06 (RLC (HL)) -> outputs 0 and o_Step = 1 immediately; a second i_Start before o_Done -> ignored.
- STEPS_PER_CYCLE = 8, ALU_STEP = 5, DATA_STEP = 7, opcode 0x10 (RL B) -> o_ALU_En only on o_Step = 0x20, o_Done on 0x80.
